// File: rtl/ram_datapath_ctrl_pkg.sv
// Shared definitions for the ram_datapath sequencer: opcodes, ALU function selects,
// FSM states and the packed control word passed from the decoder to the top level.
package ram_datapath_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_ORR  = 4'd4;
  localparam logic [3:0] OP_LDUR = 4'd5;
  localparam logic [3:0] OP_STUR = 4'd6;
  localparam logic [3:0] OP_CBZ  = 4'd7;
  localparam logic [3:0] OP_BR   = 4'd8;

  // FS[4:2] picks the function, FS[1] inverts B, FS[0] inverts A.
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_LD_ADDR, S_LD_WAIT, S_ST, S_CBZ, S_BR, S_ILL
  } state_t;

  typedef struct packed {
    logic       w, en_b, en_alu, en_addr, k_sel, pc_sel, c0, cs, we, oe;
    logic [4:0] sa, sb, da, fs;
    logic       pc_load, done, illegal;
  } ctrl_word_t;

  localparam int CW_W = $bits(ctrl_word_t);

  function automatic state_t dispatch(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_AND, OP_ORR: return S_EXEC;
      OP_LDUR: return S_LD_ADDR;
      OP_STUR: return S_ST;
      OP_CBZ:  return S_CBZ;
      OP_BR:   return S_BR;
      default: return S_ILL;
    endcase
  endfunction

endpackage

// File: rtl/ram_datapath_ctrl_decode.sv
// Purely combinational map of {state, latched instruction, Z flag} to the datapath control word.
// Every field not driven by the current state stays at 0 (the NOP word).
module ctrl_word_decode
  import ram_datapath_ctrl_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [2:0]      state,
  input  logic [3:0]      op,
  input  logic [4:0]      rd,
  input  logic [4:0]      rn,
  input  logic [4:0]      rm,
  input  logic [DW-1:0]   imm,
  input  logic            status_z,
  input  logic            cnt_zero,
  output logic [CW_W-1:0] cw,
  output logic [DW-1:0]   k
);

  ctrl_word_t c;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    c = '0;
    k = '0;
    case (state_t'(state))
      S_EXEC: begin
        c.sa     = rn;
        c.sb     = rm;
        c.da     = rd;
        k        = imm;
        c.k_sel  = (op == OP_ADDI);
        c.en_alu = 1'b1;
        c.w      = (rd != XZR);
        c.done   = 1'b1;
        case (op)
          OP_SUB: begin
            c.fs = FS_SUB;
            c.c0 = 1'b1;
          end
          OP_AND:  c.fs = FS_AND;
          OP_ORR:  c.fs = FS_OR;
          default: c.fs = FS_ADD;
        endcase
      end
      S_LD_ADDR, S_LD_WAIT: begin
        c.sa      = rn;
        k         = imm;
        c.k_sel   = 1'b1;
        c.fs      = FS_ADD;
        c.en_addr = 1'b1;
        c.cs      = 1'b1;
        // The wait cycles keep the address on the bus and open the RAM output.
        if (state_t'(state) == S_LD_WAIT) begin
          c.oe   = 1'b1;
          c.da   = rd;
          c.w    = cnt_zero && (rd != XZR);
          c.done = cnt_zero;
        end
      end
      S_ST: begin
        c.sa      = rn;
        k         = imm;
        c.k_sel   = 1'b1;
        c.fs      = FS_ADD;
        c.en_addr = 1'b1;
        c.sb      = rd;
        c.en_b    = 1'b1;
        c.cs      = 1'b1;
        c.we      = 1'b1;
        c.done    = 1'b1;
      end
      S_CBZ: begin
        c.sa      = rd;
        c.k_sel   = 1'b1;
        c.fs      = FS_ADD;
        c.pc_load = status_z;
        c.done    = 1'b1;
      end
      S_BR: begin
        c.sa      = rn;
        c.pc_sel  = 1'b1;
        c.pc_load = 1'b1;
        c.done    = 1'b1;
      end
      S_ILL: begin
        c.done    = 1'b1;
        c.illegal = 1'b1;
      end
      default: ;
    endcase
    cw = c;
  end

endmodule

// File: rtl/ram_datapath_ctrl.sv
// Multi-cycle sequencer driving ram_datapath's control inputs: one instruction per handshake,
// FSM + instruction register + read-latency counter here, control word from ctrl_word_decode.
module ram_datapath_ctrl
  import ram_datapath_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DW     = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    op,
  input  logic [4:0]    rd,
  input  logic [4:0]    rn,
  input  logic [4:0]    rm,
  input  logic [DW-1:0] imm,
  input  logic [3:0]    Status,
  output logic          W,
  output logic          EN_B,
  output logic          EN_ALU,
  output logic          EN_ADDR,
  output logic          K_SEL,
  output logic          PC_SEL,
  output logic          C0,
  output logic          CS,
  output logic          WE,
  output logic          OE,
  output logic [4:0]    SA,
  output logic [4:0]    SB,
  output logic [4:0]    DA,
  output logic [4:0]    FS,
  output logic [DW-1:0] K,
  output logic          pc_load,
  output logic          done,
  output logic          illegal
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t        state, state_nx;
  logic [3:0]    op_q;
  logic [4:0]    rd_q, rn_q, rm_q;
  logic [DW-1:0] imm_q;
  logic [2:0]    cnt;
  logic [CW_W-1:0] cw;
  ctrl_word_t    cw_s;

  // Only the Z flag steers this sequencer; V, C and N are for other consumers.
  logic status_unused;
  assign status_unused = &{1'b0, Status[3:1]};

  assign instr_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
      imm_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (instr_valid && instr_ready) begin
        op_q  <= op;
        rd_q  <= rd;
        rn_q  <= rn;
        rm_q  <= rm;
        imm_q <= imm;
      end
      if (state == S_LD_ADDR)
        cnt <= CNT_INIT;
      else if (state == S_LD_WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (instr_valid) state_nx = dispatch(op);
      S_LD_ADDR: state_nx = S_LD_WAIT;
      S_LD_WAIT: if (cnt == 3'd0) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  ctrl_word_decode #(.DW(DW)) u_decode (
    .state    (state),
    .op       (op_q),
    .rd       (rd_q),
    .rn       (rn_q),
    .rm       (rm_q),
    .imm      (imm_q),
    .status_z (Status[0]),
    .cnt_zero (cnt == 3'd0),
    .cw       (cw),
    .k        (K)
  );

  assign cw_s    = ctrl_word_t'(cw);
  assign W       = cw_s.w;
  assign EN_B    = cw_s.en_b;
  assign EN_ALU  = cw_s.en_alu;
  assign EN_ADDR = cw_s.en_addr;
  assign K_SEL   = cw_s.k_sel;
  assign PC_SEL  = cw_s.pc_sel;
  assign C0      = cw_s.c0;
  assign CS      = cw_s.cs;
  assign WE      = cw_s.we;
  assign OE      = cw_s.oe;
  assign SA      = cw_s.sa;
  assign SB      = cw_s.sb;
  assign DA      = cw_s.da;
  assign FS      = cw_s.fs;
  assign pc_load = cw_s.pc_load;
  assign done    = cw_s.done;
  assign illegal = cw_s.illegal;

endmodule
